// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Groups the signals between the instruction-fetch port, the data load/store port,
//   the shared single-port RAM and the arbiter.
//   modport master : requesters and RAM side. It drives the request buses and ram_rdata, and
//                    observes the grants, returned data and RAM strobes.
//   modport slave  : the arbiter. It drives the grants, rvalid/rdata, hold_if and the RAM
//                    command bus.
//   Signals
//     d_req/d_we/d_addr/d_wdata/d_wmask : data access request (byte address, lane-aligned data)
//     d_gnt/d_rvalid/d_rdata            : data accept, load return
//     i_req/i_addr                      : fetch request (byte address)
//     i_gnt/i_rvalid/i_rdata            : fetch accept, fetch return
//     hold_if                           : fetch requested but not granted this cycle
//     ram_en/ram_we/ram_addr/ram_wdata/ram_wmask : RAM command (word address)
//     ram_rdata                         : RAM read data, RD_LAT cycles after a read strobe
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              hold_if;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wmask;
  logic [31:0]       ram_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata,
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    input  hold_if,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
    output ram_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata,
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    output hold_if,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
    input  ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, word-wide, sync-read RAM between instruction fetch (I) and
//   data load/store (D). Exactly one access wins each cycle, with the grant decided
//   combinationally in that cycle. D has priority over I. Reads in flight are tracked in an
//   RD_LAT-deep tag pipeline so that each returned word is steered to the port that asked for it.
//   Ports
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : mem_port_arbiter_if.slave (request ports, returns, hold_if, RAM command/data)
//   Parameters
//     ADDR_W     : RAM word-address width. Must match the interface's ADDR_W.
//     RD_LAT     : RAM read latency in cycles, 1..4
//     STARVE_MAX : number of consecutive denied fetch cycles after which I beats D
//   Configuration macro
//     MEM_ARB_STARVE_GUARD_EN : if defined, enables the fetch starvation guard. If undefined,
//                               priority is strictly D > I.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  // ---------------------------------------------------------------- starvation guard
  logic i_priority;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_reg;

  assign i_priority = (starve_cnt_reg == CNT_W'(STARVE_MAX));

  // Saturates at STARVE_MAX. The cycle in which the counter sits at STARVE_MAX grants I,
  // and that grant clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (bus.i_gnt || !bus.i_req) begin
      starve_cnt_reg <= '0;
    end else if (!i_priority) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_starve_max;
  assign i_priority        = 1'b0;
  assign unused_starve_max = (STARVE_MAX > 0);
`endif

  // ---------------------------------------------------------------- arbitration
  // The grant is gated by rst_n so that nothing reaches the RAM while reset is held.
  logic d_win;
  logic i_win;
  logic d_store;

  assign d_win   = rst_n & bus.d_req & ~(i_priority & bus.i_req);
  assign i_win   = rst_n & bus.i_req & ~d_win;
  assign d_store = d_win & bus.d_we;

  assign bus.d_gnt   = d_win;
  assign bus.i_gnt   = i_win;
  assign bus.hold_if = bus.i_req & ~i_win;

  assign bus.ram_en    = d_win | i_win;
  assign bus.ram_we    = d_store;
  assign bus.ram_addr  = d_win ? bus.d_addr[ADDR_W+1:2] :
                         i_win ? bus.i_addr[ADDR_W+1:2] : '0;
  assign bus.ram_wdata = d_store ? bus.d_wdata : 32'h0;
  assign bus.ram_wmask = d_store ? bus.d_wmask : 4'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0],
                              bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0]};

  // ---------------------------------------------------------------- tag pipeline
  // Stage gi holds the read that was granted gi+1 cycles ago. A new entry is pushed every
  // cycle, with the valid bit cleared when the RAM was idle or was doing a store. The owner
  // bit is 1 for I and 0 for D.
  logic [RD_LAT-1:0] tag_valid_reg;
  logic [RD_LAT-1:0] tag_owner_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg[0] <= 1'b0;
      tag_owner_reg[0] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= (d_win & ~bus.d_we) | i_win;
      tag_owner_reg[0] <= i_win;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_owner_reg[gi] <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_owner_reg[gi] <= tag_owner_reg[gi-1];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- read return
  // The last tag stage lines up with ram_rdata. In a return cycle the RAM word is passed
  // straight to the owning port. Otherwise each port shows the value it captured last time.
  logic        d_hit;
  logic        i_hit;
  logic [31:0] d_rdata_reg;
  logic [31:0] i_rdata_reg;

  assign d_hit = tag_valid_reg[RD_LAT-1] & ~tag_owner_reg[RD_LAT-1];
  assign i_hit = tag_valid_reg[RD_LAT-1] &  tag_owner_reg[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata_reg <= 32'h0;
      i_rdata_reg <= 32'h0;
    end else begin
      if (d_hit) d_rdata_reg <= bus.ram_rdata;
      if (i_hit) i_rdata_reg <= bus.ram_rdata;
    end
  end

  assign bus.d_rvalid = d_hit;
  assign bus.i_rvalid = i_hit;
  assign bus.d_rdata  = d_hit ? bus.ram_rdata : d_rdata_reg;
  assign bus.i_rdata  = i_hit ? bus.ram_rdata : i_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances share clk and rst_n:
//     dut2 : RD_LAT=2 (reset, fetch-only, conflict, store, starvation)
//     dut3 : RD_LAT=3 (interleaved D/I/D reads)
//   Each instance has a RAM model whose words power up as 32'hA000_0000 | word_index.
//   The RAM is reloaded while reset is low.
//   Inputs are driven 1 time unit after posedge, and outputs are sampled on negedge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(12)) bus2 ();
  mem_port_arbiter_if #(.ADDR_W(12)) bus3 ();

  mem_port_arbiter #(.ADDR_W(12), .RD_LAT(2), .STARVE_MAX(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  mem_port_arbiter #(.ADDR_W(12), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // RAM models: a write applies its byte mask, and a read result is delayed by a pipeline
  // of depth RD_LAT.
  logic [31:0] mem2 [0:4095];
  logic [31:0] pipe2 [0:1];
  logic [31:0] mem3 [0:4095];
  logic [31:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 4096; w++) mem2[w] <= 32'hA000_0000 | w;
    end else if (bus2.ram_en) begin
      if (bus2.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus2.ram_wmask[b]) mem2[bus2.ram_addr][8*b +: 8] <= bus2.ram_wdata[8*b +: 8];
      end
      pipe2[0] <= mem2[bus2.ram_addr];
    end
    pipe2[1] <= pipe2[0];
  end
  assign bus2.ram_rdata = pipe2[1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 4096; w++) mem3[w] <= 32'hA000_0000 | w;
    end else if (bus3.ram_en) begin
      if (bus3.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus3.ram_wmask[b]) mem3[bus3.ram_addr][8*b +: 8] <= bus3.ram_wdata[8*b +: 8];
      end
      pipe3[0] <= mem3[bus3.ram_addr];
    end
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.ram_rdata = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle2();
    bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = 0; bus2.d_wdata = 0; bus2.d_wmask = 0;
    bus2.i_req = 0; bus2.i_addr = 0;
  endtask

  task automatic idle3();
    bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = 0; bus3.d_wdata = 0; bus3.d_wmask = 0;
    bus3.i_req = 0; bus3.i_addr = 0;
  endtask

  // ------------------------------------------------------------------ test 1
  task automatic test_reset();
    rst_n = 0;
    idle2(); idle3();
    bus2.d_req = 1; bus2.d_addr = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus2.d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt: got %b want 0", bus2.d_gnt); end
    n_cmp++; if (bus2.i_gnt !== 1'b0) begin n_err++; $display("FAIL rst_i_gnt: got %b want 0", bus2.i_gnt); end
    n_cmp++; if (bus2.ram_en !== 1'b0) begin n_err++; $display("FAIL rst_ram_en: got %b want 0", bus2.ram_en); end
    n_cmp++; if (bus2.ram_addr !== 12'h0) begin n_err++; $display("FAIL rst_ram_addr: got %h want 000", bus2.ram_addr); end
    n_cmp++; if (bus2.d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_d_rvalid: got %b want 0", bus2.d_rvalid); end
    n_cmp++; if (bus2.d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata: got %h want 0", bus2.d_rdata); end
    n_cmp++; if (bus2.i_rdata !== 32'h0) begin n_err++; $display("FAIL rst_i_rdata: got %h want 0", bus2.i_rdata); end
    n_cmp++; if (bus2.hold_if !== 1'b0) begin n_err++; $display("FAIL rst_hold_if: got %b want 0", bus2.hold_if); end
    $display("reset: outputs idle while rst_n=0");
    tick();
    rst_n = 1;                       // the held load is granted in this cycle
    @(negedge clk);
    n_cmp++; if (bus2.d_gnt !== 1'b1) begin n_err++; $display("FAIL rst_load_gnt: got %b want 1", bus2.d_gnt); end
    n_cmp++; if (bus2.ram_addr !== 12'h010) begin n_err++; $display("FAIL rst_load_addr: got %h want 010", bus2.ram_addr); end
    tick();
    rst_n = 0;                       // read is now in flight and must be dropped
    idle2();
    @(negedge clk);
    n_cmp++; if (bus2.d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rvalid: got %b want 0", bus2.d_rvalid); end
    n_cmp++; if (bus2.ram_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_ram_en: got %b want 0", bus2.ram_en); end
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (bus2.d_rvalid !== 1'b0 || bus2.i_rvalid !== 1'b0) begin
        n_err++; $display("FAIL rst_drop_c%0d: got d_rvalid=%b i_rvalid=%b want 0 0", c, bus2.d_rvalid, bus2.i_rvalid);
      end
      tick();
    end
    $display("reset: in-flight read dropped");
  endtask

  // ------------------------------------------------------------------ test 2
  task automatic test_i_only();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin bus2.i_req = 1; bus2.i_addr = 32'(4 * c); end
      else idle2();
      @(negedge clk);
      n_cmp++; if (bus2.i_gnt !== (c < 3)) begin n_err++; $display("FAIL ionly_gnt_c%0d: got %b want %b", c, bus2.i_gnt, (c < 3)); end
      if (c < 3) begin
        n_cmp++; if (bus2.ram_addr !== 12'(c) || bus2.ram_en !== 1'b1 || bus2.ram_we !== 1'b0 || bus2.hold_if !== 1'b0) begin
          n_err++; $display("FAIL ionly_ram_c%0d: got addr=%h en=%b we=%b hold=%b want addr=%h en=1 we=0 hold=0",
                            c, bus2.ram_addr, bus2.ram_en, bus2.ram_we, bus2.hold_if, 12'(c));
        end
      end
      n_cmp++; if (bus2.i_rvalid !== (c >= 2) || bus2.d_rvalid !== 1'b0) begin
        n_err++; $display("FAIL ionly_rvalid_c%0d: got i=%b d=%b want i=%b d=0", c, bus2.i_rvalid, bus2.d_rvalid, (c >= 2));
      end
      if (c >= 2) begin
        n_cmp++; if (bus2.i_rdata !== (32'hA000_0000 | 32'(c - 2))) begin
          n_err++; $display("FAIL ionly_rdata_c%0d: got %h want %h", c, bus2.i_rdata, 32'hA000_0000 | 32'(c - 2));
        end
      end
      $display("i_only cycle %0d: i_gnt=%b ram_addr=%h i_rvalid=%b i_rdata=%h", c, bus2.i_gnt, bus2.ram_addr, bus2.i_rvalid, bus2.i_rdata);
      tick();
    end
  endtask

  // ------------------------------------------------------------------ test 3
  task automatic test_conflict();
    bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 32'h100;
    bus2.i_req = 1; bus2.i_addr = 32'h20;
    @(negedge clk);
    n_cmp++; if (bus2.d_gnt !== 1'b1 || bus2.i_gnt !== 1'b0 || bus2.hold_if !== 1'b1) begin
      n_err++; $display("FAIL conf_c0: got d_gnt=%b i_gnt=%b hold=%b want 1 0 1", bus2.d_gnt, bus2.i_gnt, bus2.hold_if);
    end
    n_cmp++; if (bus2.ram_addr !== 12'h040) begin n_err++; $display("FAIL conf_addr_c0: got %h want 040", bus2.ram_addr); end
    tick();
    bus2.d_req = 0;
    @(negedge clk);
    n_cmp++; if (bus2.i_gnt !== 1'b1 || bus2.hold_if !== 1'b0 || bus2.ram_addr !== 12'h008) begin
      n_err++; $display("FAIL conf_c1: got i_gnt=%b hold=%b addr=%h want 1 0 008", bus2.i_gnt, bus2.hold_if, bus2.ram_addr);
    end
    tick();
    idle2();
    @(negedge clk);
    n_cmp++; if (bus2.d_rvalid !== 1'b1 || bus2.i_rvalid !== 1'b0 || bus2.d_rdata !== 32'hA000_0040) begin
      n_err++; $display("FAIL conf_c2: got d_rvalid=%b i_rvalid=%b d_rdata=%h want 1 0 a0000040", bus2.d_rvalid, bus2.i_rvalid, bus2.d_rdata);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (bus2.i_rvalid !== 1'b1 || bus2.d_rvalid !== 1'b0 || bus2.i_rdata !== 32'hA000_0008) begin
      n_err++; $display("FAIL conf_c3: got i_rvalid=%b d_rvalid=%b i_rdata=%h want 1 0 a0000008", bus2.i_rvalid, bus2.d_rvalid, bus2.i_rdata);
    end
    n_cmp++; if (bus2.d_rdata !== 32'hA000_0040) begin n_err++; $display("FAIL conf_hold_rdata: got %h want a0000040", bus2.d_rdata); end
    $display("conflict: D won, I regranted next cycle, data returned to both ports");
    tick();
  endtask

  // ------------------------------------------------------------------ test 4
  task automatic test_store();
    bus2.d_req = 1; bus2.d_we = 1; bus2.d_addr = 32'h10; bus2.d_wdata = 32'hDEAD_BEEF; bus2.d_wmask = 4'b0011;
    bus2.i_req = 1; bus2.i_addr = 32'h10;   // same word, fetched in the same cycle
    @(negedge clk);
    n_cmp++; if (bus2.d_gnt !== 1'b1 || bus2.i_gnt !== 1'b0 || bus2.hold_if !== 1'b1) begin
      n_err++; $display("FAIL st_gnt: got d_gnt=%b i_gnt=%b hold=%b want 1 0 1", bus2.d_gnt, bus2.i_gnt, bus2.hold_if);
    end
    n_cmp++; if (bus2.ram_en !== 1'b1 || bus2.ram_we !== 1'b1 || bus2.ram_addr !== 12'h004 ||
                 bus2.ram_wmask !== 4'b0011 || bus2.ram_wdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL st_ram: got en=%b we=%b addr=%h mask=%b wdata=%h want 1 1 004 0011 deadbeef",
                        bus2.ram_en, bus2.ram_we, bus2.ram_addr, bus2.ram_wmask, bus2.ram_wdata);
    end
    tick();
    bus2.d_req = 0; bus2.d_we = 0; bus2.d_wmask = 0; bus2.d_wdata = 0;
    @(negedge clk);
    n_cmp++; if (bus2.i_gnt !== 1'b1 || bus2.ram_wmask !== 4'b0000) begin
      n_err++; $display("FAIL st_regrant: got i_gnt=%b mask=%b want 1 0000", bus2.i_gnt, bus2.ram_wmask);
    end
    tick();
    idle2();
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus2.d_rvalid !== 1'b0) begin n_err++; $display("FAIL st_no_drvalid_c%0d: got %b want 0", c, bus2.d_rvalid); end
      n_cmp++; if (bus2.i_rvalid !== (c == 3)) begin n_err++; $display("FAIL st_irvalid_c%0d: got %b want %b", c, bus2.i_rvalid, (c == 3)); end
      if (c == 3) begin
        n_cmp++; if (bus2.i_rdata !== 32'hA000_BEEF) begin n_err++; $display("FAIL st_newdata: got %h want a000beef", bus2.i_rdata); end
      end
      tick();
    end
    $display("store: masked write accepted, fetch of same word saw new data");
  endtask

  // ------------------------------------------------------------------ test 5
  task automatic test_interleave();
    for (int c = 0; c < 7; c++) begin
      idle3();
      if (c == 0) begin bus3.d_req = 1; bus3.d_addr = 32'h200; end
      if (c == 1) begin bus3.i_req = 1; bus3.i_addr = 32'h204; end
      if (c == 2) begin bus3.d_req = 1; bus3.d_addr = 32'h208; end
      @(negedge clk);
      n_cmp++; if (bus3.d_gnt !== (c == 0 || c == 2) || bus3.i_gnt !== (c == 1)) begin
        n_err++; $display("FAIL il_gnt_c%0d: got d=%b i=%b want d=%b i=%b", c, bus3.d_gnt, bus3.i_gnt, (c == 0 || c == 2), (c == 1));
      end
      n_cmp++; if (bus3.d_rvalid !== (c == 3 || c == 5) || bus3.i_rvalid !== (c == 4)) begin
        n_err++; $display("FAIL il_rvalid_c%0d: got d=%b i=%b want d=%b i=%b", c, bus3.d_rvalid, bus3.i_rvalid, (c == 3 || c == 5), (c == 4));
      end
      if (c == 3) begin
        n_cmp++; if (bus3.d_rdata !== 32'hA000_0080) begin n_err++; $display("FAIL il_d0_data: got %h want a0000080", bus3.d_rdata); end
      end
      if (c == 4) begin
        n_cmp++; if (bus3.i_rdata !== 32'hA000_0081) begin n_err++; $display("FAIL il_i_data: got %h want a0000081", bus3.i_rdata); end
      end
      if (c == 5) begin
        n_cmp++; if (bus3.d_rdata !== 32'hA000_0082) begin n_err++; $display("FAIL il_d1_data: got %h want a0000082", bus3.d_rdata); end
      end
      $display("interleave cycle %0d: d_rvalid=%b d_rdata=%h i_rvalid=%b i_rdata=%h",
               c, bus3.d_rvalid, bus3.d_rdata, bus3.i_rvalid, bus3.i_rdata);
      tick();
    end
  endtask

  // ------------------------------------------------------------------ test 6
  task automatic test_starve();
    bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 32'h0;
    bus2.i_req = 1; bus2.i_addr = 32'h4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus2.i_gnt !== (c == 4) || bus2.d_gnt !== (c != 4)) begin
        n_err++; $display("FAIL starve_on_c%0d: got i_gnt=%b d_gnt=%b want %b %b", c, bus2.i_gnt, bus2.d_gnt, (c == 4), (c != 4));
      end
      $display("starve guard cycle %0d: d_gnt=%b i_gnt=%b", c, bus2.d_gnt, bus2.i_gnt);
      tick();
    end
`else
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (bus2.i_gnt !== 1'b0 || bus2.d_gnt !== 1'b1 || bus2.hold_if !== 1'b1) begin
        n_err++; $display("FAIL starve_off_c%0d: got i_gnt=%b d_gnt=%b hold=%b want 0 1 1", c, bus2.i_gnt, bus2.d_gnt, bus2.hold_if);
      end
      $display("strict priority cycle %0d: d_gnt=%b i_gnt=%b", c, bus2.d_gnt, bus2.i_gnt);
      tick();
    end
`endif
    idle2();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 0;
    idle2();
    idle3();
    test_reset();
    test_i_only();
    test_conflict();
    test_store();
    test_interleave();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion want finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
